// File: rtl/if_stage_pkg.sv
// ----------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the bittyCore fetch stage: bus widths, the zero word,
// ROM enable levels, the bubble instruction, the fetch FSM state encoding and
// a word-alignment helper.
// ----------------------------------------------------------------------------
package if_stage_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;

  localparam logic [InstAddrBus-1:0] ZeroWord = '0;

  localparam logic ReadEnable  = 1'b1;
  localparam logic ReadDisable = 1'b0;

  // addi x0, x0, 0
  localparam logic [InstBus-1:0] NopInst = 32'h0000_0013;

  typedef enum logic {
    S_HOLD = 1'b0,
    S_RUN  = 1'b1
  } if_state_e;

  // Force a byte address onto a 4-byte instruction boundary.
  function automatic logic [InstAddrBus-1:0] align_word(input logic [InstAddrBus-1:0] addr);
    return {addr[InstAddrBus-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register. Holds the fetched instruction and its PC for the
// decode stage.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   hold_i             keep current contents
//   bubble_i           load the bubble word (wins over hold_i)
//   pc_i, inst_i       PC and instruction to capture
//   id_pc_o            PC of the held instruction
//   id_inst_o          held instruction
//   id_valid_o         1 = real instruction, 0 = bubble
//
// A bubble leaves id_pc_o untouched; only the word and the valid bit change.
// ----------------------------------------------------------------------------
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [InstBus-1:0] NOP_INST = NopInst
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold_i,
  input  logic                   bubble_i,
  input  logic [InstAddrBus-1:0] pc_i,
  input  logic [InstBus-1:0]     inst_i,
  output logic [InstAddrBus-1:0] id_pc_o,
  output logic [InstBus-1:0]     id_inst_o,
  output logic                   id_valid_o
);

  logic [InstAddrBus-1:0] pc_q, pc_d;
  logic [InstBus-1:0]     inst_q, inst_d;
  logic                   valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (bubble_i) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (!hold_i) begin
      pc_d    = pc_i;
      inst_d  = inst_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= ZeroWord;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign id_pc_o    = pc_q;
  assign id_inst_o  = inst_q;
  assign id_valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage of bittyCore. Owns the PC, drives the combinational
// instruction ROM, and feeds decode through the IF/ID register. Applies
// stalls from hazard control and redirects from execute.
//
// Parameters:
//   RESET_PC   first fetch address after reset
//   TRAP_PC    redirect target for a misaligned jump (macro build only)
//   NOP_INST   bubble word
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   stall_i                  hold PC and IF/ID
//   jump_flag_i, jump_addr_i redirect request and target
//   rom_ce_o                 ROM chip enable (registered)
//   rom_addr_o               ROM byte address (= PC register)
//   rom_inst_i               ROM data for rom_addr_o, same cycle
//   id_pc_o, id_inst_o       IF/ID contents
//   id_valid_o               IF/ID holds a real instruction
//   if_misalign_o            one-cycle pulse after a misaligned redirect
//
// Build option: IF_MISALIGN_CHECK_EN
//   defined     misaligned targets redirect to TRAP_PC and pulse if_misalign_o
//   undefined   low two target bits are cleared, if_misalign_o stays 0
//
// State   | meaning
// --------+-----------------------------------------------------------
// S_HOLD  | ROM disabled; first edge after reset release enables it
// S_RUN   | fetching one word per cycle unless stalled or redirected
// ----------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [InstAddrBus-1:0] TRAP_PC  = 32'h0000_0004,
  parameter logic [InstBus-1:0]     NOP_INST = NopInst
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   jump_flag_i,
  input  logic [InstAddrBus-1:0] jump_addr_i,
  output logic                   rom_ce_o,
  output logic [InstAddrBus-1:0] rom_addr_o,
  input  logic [InstBus-1:0]     rom_inst_i,
  output logic [InstAddrBus-1:0] id_pc_o,
  output logic [InstBus-1:0]     id_inst_o,
  output logic                   id_valid_o,
  output logic                   if_misalign_o
);

  if_state_e              state_q, state_d;
  logic [InstAddrBus-1:0] pc_q, pc_d;
  logic                   rom_ce_q, rom_ce_d;
  logic                   misalign_q, misalign_d;

  logic [InstAddrBus-1:0] redirect_pc;
  logic                   redirect_mis;
  logic                   ifid_hold;
  logic                   ifid_bubble;

`ifdef IF_MISALIGN_CHECK_EN
  assign redirect_mis = |jump_addr_i[1:0];
  assign redirect_pc  = redirect_mis ? TRAP_PC : align_word(jump_addr_i);
`else
  logic unused_trap_pc;
  assign unused_trap_pc = ^TRAP_PC;
  assign redirect_mis   = 1'b0;
  assign redirect_pc    = align_word(jump_addr_i);
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rom_ce_d    = rom_ce_q;
    misalign_d  = 1'b0;
    ifid_hold   = 1'b1;
    ifid_bubble = 1'b0;
    case (state_q)
      S_HOLD: begin
        // IF/ID stays at reset contents: the ROM was disabled this cycle.
        state_d  = S_RUN;
        rom_ce_d = ReadEnable;
        if (jump_flag_i) begin
          pc_d       = redirect_pc;
          misalign_d = redirect_mis;
        end
      end
      S_RUN: begin
        if (jump_flag_i) begin
          // The word fetched this cycle is on the wrong path; drop it.
          pc_d        = redirect_pc;
          misalign_d  = redirect_mis;
          ifid_bubble = 1'b1;
        end else if (!stall_i) begin
          pc_d      = pc_q + 32'd4;
          ifid_hold = 1'b0;
        end
      end
      default: begin
        state_d  = S_HOLD;
        rom_ce_d = ReadDisable;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_HOLD;
      pc_q       <= RESET_PC;
      rom_ce_q   <= ReadDisable;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rom_ce_q   <= rom_ce_d;
      misalign_q <= misalign_d;
    end
  end

  assign rom_ce_o      = rom_ce_q;
  assign rom_addr_o    = pc_q;
  assign if_misalign_o = misalign_q;

  if_id_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .hold_i    (ifid_hold),
    .bubble_i  (ifid_bubble),
    .pc_i      (pc_q),
    .inst_i    (rom_inst_i),
    .id_pc_o   (id_pc_o),
    .id_inst_o (id_inst_o),
    .id_valid_o(id_valid_o)
  );

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] TRP_PC  = 32'h0000_0004;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
  logic        if_misalign_o;

  int vectors = 0;
  int miscompares = 0;

  if_stage #(
    .RESET_PC(RST_PC),
    .TRAP_PC (TRP_PC),
    .NOP_INST(NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .rom_ce_o     (rom_ce_o),
    .rom_addr_o   (rom_addr_o),
    .rom_inst_i   (rom_inst_i),
    .id_pc_o      (id_pc_o),
    .id_inst_o    (id_inst_o),
    .id_valid_o   (id_valid_o),
    .if_misalign_o(if_misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: 0x11,0x22,0x33 at words 0..2, an address-derived pattern elsewhere.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h11;
    if (a == 32'd4) return 32'h22;
    if (a == 32'd8) return 32'h33;
    return a ^ 32'hC0DE_0000;
  endfunction

  assign rom_inst_i = rom_ce_o ? rom_word(rom_addr_o) : 32'h0;

  // ---------------- reference model (architectural view) ----------------
  bit          m_running = 0;
  logic [31:0] m_pc      = RST_PC;
  logic [31:0] m_id_pc   = 32'h0;
  logic [31:0] m_id_inst = NOP;
  bit          m_valid   = 0;
  bit          m_mis     = 0;

  function automatic logic [31:0] target_of(input logic [31:0] a, output bit mis);
`ifdef IF_MISALIGN_CHECK_EN
    mis = (a % 4) != 0;
    return mis ? TRP_PC : a - (a % 4);
`else
    mis = 0;
    return a - (a % 4);
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    bit mis;
    logic [31:0] tgt;
    if (rst) begin
      m_running = 0;
      m_pc      = RST_PC;
      m_id_pc   = 32'h0;
      m_id_inst = NOP;
      m_valid   = 0;
      m_mis     = 0;
    end else begin
      m_mis = 0;
      if (!m_running) begin
        m_running = 1;
        if (jump_flag_i) begin
          tgt = target_of(jump_addr_i, mis);
          m_pc = tgt;
          m_mis = mis;
        end
      end else if (jump_flag_i) begin
        tgt = target_of(jump_addr_i, mis);
        m_pc = tgt;
        m_mis = mis;
        m_id_inst = NOP;
        m_valid = 0;
      end else if (!stall_i) begin
        m_id_pc = m_pc;
        m_id_inst = rom_word(m_pc);
        m_valid = 1;
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cmp("rom_ce",   {31'b0, rom_ce_o},      {31'b0, m_running});
    cmp("rom_addr", rom_addr_o,             m_pc);
    cmp("id_pc",    id_pc_o,                m_id_pc);
    cmp("id_inst",  id_inst_o,              m_id_inst);
    cmp("id_valid", {31'b0, id_valid_o},    {31'b0, m_valid});
    cmp("misalign", {31'b0, if_misalign_o}, {31'b0, m_mis});
  end

  // Apply inputs, let one rising edge pass, land just after the next falling edge.
  task automatic tick(input bit s, input bit j, input logic [31:0] a);
    stall_i = s;
    jump_flag_i = j;
    jump_addr_i = a;
    @(negedge clk);
    #1;
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    rst = 1'b1;
    stall_i = 1'b0;
    jump_flag_i = 1'b0;
    jump_addr_i = 32'h0;
    @(negedge clk);
    @(negedge clk);
    #1;
    cmp("lit_reset_inst", id_inst_o, 32'h13);
    rst = 1'b0;
    cmp("lit_cycle0_ce", {31'b0, rom_ce_o}, 32'd0);

    tick(0, 0, 0);
    cmp("lit_cycle1_ce", {31'b0, rom_ce_o}, 32'd1);
    cmp("lit_cycle1_valid", {31'b0, id_valid_o}, 32'd0);
    tick(0, 0, 0);
    cmp("lit_first_inst", id_inst_o, 32'h11);
    cmp("lit_first_pc", id_pc_o, 32'h0);
    tick(0, 0, 0);
    cmp("lit_second_inst", id_inst_o, 32'h22);
    cmp("lit_second_pc", id_pc_o, 32'h4);

    // stall three cycles at pc=8
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0);
      cmp("lit_stall_addr", rom_addr_o, 32'h8);
      cmp("lit_stall_inst", id_inst_o, 32'h22);
    end
    tick(0, 0, 0);
    cmp("lit_resume_inst", id_inst_o, 32'h33);
    cmp("lit_resume_pc", id_pc_o, 32'h8);
    tick(0, 0, 0);
    cmp("lit_pc10", rom_addr_o, 32'h10);

    // jump over stall
    tick(1, 1, 32'h40);
    cmp("lit_jump_valid", {31'b0, id_valid_o}, 32'd0);
    cmp("lit_jump_inst", id_inst_o, 32'h13);
    cmp("lit_jump_addr", rom_addr_o, 32'h40);
    cmp("lit_jump_idpc", id_pc_o, 32'hC);
    tick(0, 0, 0);
    cmp("lit_target_pc", id_pc_o, 32'h40);
    cmp("lit_target_valid", {31'b0, id_valid_o}, 32'd1);

    // wrap
    tick(0, 1, 32'hFFFF_FFFC);
    cmp("lit_wrap_addr", rom_addr_o, 32'hFFFF_FFFC);
    tick(0, 0, 0);
    cmp("lit_wrap_next", rom_addr_o, 32'h0);
    tick(0, 0, 0);

    // misaligned jump
    tick(0, 1, 32'h42);
`ifdef IF_MISALIGN_CHECK_EN
    cmp("lit_mis_addr", rom_addr_o, 32'h4);
    cmp("lit_mis_pulse", {31'b0, if_misalign_o}, 32'd1);
`else
    cmp("lit_mis_addr", rom_addr_o, 32'h40);
    cmp("lit_mis_pulse", {31'b0, if_misalign_o}, 32'd0);
`endif
    tick(0, 0, 0);
    cmp("lit_mis_pulse_end", {31'b0, if_misalign_o}, 32'd0);
    tick(1, 0, 0);
    tick(0, 1, 32'h0000_0103);
    tick(0, 1, 32'h0000_0200);
    tick(0, 0, 0);
    tick(0, 0, 0);

    // asynchronous reset between edges
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    cmp("lit_async_ce", {31'b0, rom_ce_o}, 32'd0);
    cmp("lit_async_valid", {31'b0, id_valid_o}, 32'd0);
    cmp("lit_async_addr", rom_addr_o, RST_PC);
    cmp("lit_async_inst", id_inst_o, 32'h13);
    @(negedge clk);
    #1;
    rst = 1'b0;
    // redirect on the very first edge out of reset
    tick(0, 1, 32'h20);
    cmp("lit_hold_jump_addr", rom_addr_o, 32'h20);
    cmp("lit_hold_jump_valid", {31'b0, id_valid_o}, 32'd0);
    tick(0, 0, 0);
    cmp("lit_hold_jump_idpc", id_pc_o, 32'h20);
    for (int i = 0; i < 6; i++) tick((i % 3) == 1, 0, 0);
    tick(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
